ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide sequencer attached to the EX stage. It owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces ALUStall for the EX datapath whenever EX needs HI/LO, or a new mul/div op, while an operation is in flight.
- Independent instructions keep flowing while it is busy; ALUStall is only raised on HI/LO or mul/div use.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Stall  input  1  EX-stage hold from other hazard sources; must exclude this block's ALUStall
- Flush  input  1  CP0 flush; kills the instruction currently in EX
- Start  input  1  EX holds a mul/div/MTxx instruction
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others no-op
- RsData  input  WIDTH  forwarded Rs operand (dividend / multiplicand / MTxx source)
- RtData  input  WIDTH  forwarded Rt operand (divisor / multiplier)
- ReadHiLo  input  1  MFHI/MFLO currently in EX
- ReadHiSel  input  1  1 = HI, 0 = LO
- HiLoOut  output  WIDTH  combinational mux of Hi/Lo by ReadHiSel
- ALUStall  output  1  combinational stall request to EX
- Busy  output  1  operation in flight
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE, Hi=0, Lo=0, Busy=0, counter=0, internal operand registers=0. ALUStall=0 while reset is held. A reset asserted mid-operation aborts it immediately; HI/LO do not keep partial results.
- Accept condition: accept = Start & ~Flush & ~Stall & (state==IDLE). An op is launched exactly once, even if Start is held for several cycles under Stall.
- ALUStall = Busy & (ReadHiLo | Start). Combinational, with no path from Stall.
- FSM states: IDLE, ITER, FIX.
  - IDLE: on accept of MTHI/MTLO, write RsData to Hi/Lo at that edge and stay in IDLE. The written value is visible next cycle.
  - IDLE: on accept of Op 000–011, latch operand magnitudes and the sign flags (signed ops only) and go to ITER. Set counter=WIDTH and Busy=1.
  - IDLE: unknown Op is accepted and ignored.
  - ITER: one radix-2 step per cycle. Multiply is shift-add on {acc,mplier}. Divide is restoring on {rem,quot}. Decrement counter; at counter==1 go to FIX.
  - FIX: apply the sign correction (negate product, or quotient/remainder as required). Write Hi/Lo at the edge leaving FIX, go to IDLE, Busy=0.
- Latency: Busy is high for exactly WIDTH+1 = 33 cycles after the accept edge. New Hi/Lo are visible in the first cycle with Busy=0.
- Multiply result: {Hi,Lo} = 64-bit product, signed for MULT, unsigned for MULTU.
- Divide result: Lo = quotient, Hi = remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (DIV and DIVU): Lo=0xFFFFFFFF, Hi=RsData as latched. The step loop still runs the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Flush: affects only the accept cycle. An op already in ITER/FIX always completes.
- Simultaneous events:
  - ReadHiLo while Busy: stalls.
  - Start while Busy: stalls and is not accepted until IDLE.
  - MTxx while Busy: stalls, so an MTxx is never lost or overwritten by a late result.
- Operands are sampled only at the accept edge. Changes to RsData/RtData during Busy are ignored.

Test Plan:
- MULT Rs=0xFFFFFFFE, Rt=3 -> Busy 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULTU with the same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV Rs=0xFFFFFFF9, Rt=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/2 -> Lo=3, Hi=1.
- DIVU 0x1234/0 -> Lo=0xFFFFFFFF, Hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0. MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
- MFHI (ReadHiLo=1, ReadHiSel=1) in the 5th busy cycle -> ALUStall=1 until Busy falls. In the first cycle with ALUStall=0, HiLoOut equals the new Hi.
- Start+Flush=1 -> Busy stays 0, Hi/Lo unchanged. Start held with Stall=1 for 3 cycles, then 0 -> exactly one op launched (33 busy cycles, not 66). Second MULT while busy -> ALUStall=1, launched on the cycle after Busy drops.
- rst_n=0 in busy cycle 10 -> Busy=0, Hi=Lo=0 asynchronously. Then MTHI 0xDEADBEEF followed by MFHI -> HiLoOut=0xDEADBEEF, ALUStall=0.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_muldiv_unit : iterative radix-2 multiply/divide sequencer owning HI/LO
// Revision 1.0
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             ReadHiLo,
  input  logic             ReadHiSel,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             ALUStall,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / remainder
  logic [WIDTH-1:0]   low_q, low_d;     // multiplier / quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;

  logic               accept;
  logic               signed_op, sa, sb;
  logic [WIDTH:0]     mul_add;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign accept    = Start & ~Flush & ~Stall & (state_q == IDLE);
  assign signed_op = ~Op[0];
  assign sa        = signed_op & RsData[WIDTH-1];
  assign sb        = signed_op & RtData[WIDTH-1];
  assign mul_add   = low_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign prod      = {acc_q, low_q};
  assign prod_fix  = neg_res_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    rs_d      = rs_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (Op)
            3'b100: hi_d = RsData;
            3'b101: lo_d = RsData;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d  = Op[1];
              acc_d     = '0;
              low_d     = sa ? -RsData : RsData;
              opnd_d    = sb ? -RtData : RtData;
              neg_res_d = sa ^ sb;
              neg_rem_d = sa;
              div0_d    = Op[1] & (RtData == '0);
              rs_d      = RsData;
              cnt_d     = CNT_W'(WIDTH);
              state_d   = ITER;
            end
            default: ;
          endcase
        end
      end
      ITER: begin
        if (is_div_q) begin
          // Restoring step: subtract divisor only when the shifted remainder covers it
          acc_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_add[WIDTH:1];
          low_d = {mul_add[0], low_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = rs_q;
          end else begin
            lo_d = neg_res_q ? -low_q : low_q;
            hi_d = neg_rem_q ? -acc_q : acc_q;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      rs_q      <= rs_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign ALUStall = Busy & (ReadHiLo | Start);
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign HiLoOut  = ReadHiSel ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit : directed self-checking bench for ex_muldiv_unit
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Flush, Start, ReadHiLo, ReadHiSel;
  logic [2:0]  Op;
  logic [31:0] RsData, RtData;
  logic [31:0] HiLoOut, Hi, Lo;
  logic        ALUStall, Busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .Start(Start),
    .Op(Op), .RsData(RsData), .RtData(RtData), .ReadHiLo(ReadHiLo),
    .ReadHiSel(ReadHiSel), .HiLoOut(HiLoOut), .ALUStall(ALUStall),
    .Busy(Busy), .Hi(Hi), .Lo(Lo)
  );

  // Launch one op and count the busy cycles seen at falling edges.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, output int n);
    @(negedge clk);
    Start = 1'b1; Op = op; RsData = rs; RtData = rt;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Stall = 0; Flush = 0; Start = 0; ReadHiLo = 0; ReadHiSel = 0;
    Op = 0; RsData = 0; RtData = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", Busy); end
    n_cmp++; if (ALUStall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", ALUStall); end
    n_cmp++; if (Hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", Lo); end
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    run_op(3'b000, 32'hFFFFFFFE, 32'd3, n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL mult_busy got %0d want 33", n); end
    n_cmp++; if (Hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", Hi); end
    n_cmp++; if (Lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo got %h want fffffffa", Lo); end
    run_op(3'b001, 32'hFFFFFFFE, 32'd3, n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL multu_busy got %0d want 33", n); end
    n_cmp++; if (Hi !== 32'h2) begin n_bad++; $display("FAIL multu_hi got %h want 00000002", Hi); end
    n_cmp++; if (Lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL multu_lo got %h want fffffffa", Lo); end
  endtask

  task automatic test_div;
    int n;
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL div_busy got %0d want 33", n); end
    n_cmp++; if (Lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", Lo); end
    n_cmp++; if (Hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", Hi); end
    run_op(3'b011, 32'd7, 32'd2, n);
    n_cmp++; if (Lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got %h want 3", Lo); end
    n_cmp++; if (Hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got %h want 1", Hi); end
  endtask

  task automatic test_corner;
    int n;
    run_op(3'b011, 32'h1234, 32'd0, n);
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL div0_busy got %0d want 33", n); end
    n_cmp++; if (Lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo got %h want ffffffff", Lo); end
    n_cmp++; if (Hi !== 32'h1234) begin n_bad++; $display("FAIL div0_hi got %h want 00001234", Hi); end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
    n_cmp++; if (Lo !== 32'h80000000) begin n_bad++; $display("FAIL divovf_lo got %h want 80000000", Lo); end
    n_cmp++; if (Hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi got %h want 0", Hi); end
    run_op(3'b000, 32'h80000000, 32'h80000000, n);
    n_cmp++; if (Hi !== 32'h40000000) begin n_bad++; $display("FAIL multmin_hi got %h want 40000000", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_bad++; $display("FAIL multmin_lo got %h want 0", Lo); end
  endtask

  task automatic test_mfhi_stall;
    int n, st;
    @(negedge clk);
    Start = 1'b1; Op = 3'b011; RsData = 32'd7; RtData = 32'd2;
    @(negedge clk);
    Start = 1'b0; n = 1;
    while (n < 5) begin @(negedge clk); n++; end
    ReadHiLo = 1'b1; ReadHiSel = 1'b1; st = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!Busy) break;
      if (ALUStall) st++;
      @(negedge clk);
    end
    n_cmp++; if (st != 29) begin n_bad++; $display("FAIL mfhi_stall_cycles got %0d want 29", st); end
    n_cmp++; if (ALUStall !== 1'b0) begin n_bad++; $display("FAIL mfhi_release got %0b want 0", ALUStall); end
    n_cmp++; if (HiLoOut !== 32'd1) begin n_bad++; $display("FAIL mfhi_value got %h want 1", HiLoOut); end
    ReadHiLo = 1'b0; ReadHiSel = 1'b0;
  endtask

  task automatic test_stall_hold;
    int n;
    @(negedge clk);
    Start = 1'b1; Stall = 1'b1; Op = 3'b011; RsData = 32'd100; RtData = 32'd7;
    repeat (3) @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL stall_noaccept got %0b want 0", Busy); end
    Stall = 1'b0;
    @(negedge clk);
    Start = 1'b0; n = 0;
    while (Busy && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL stall_once got %0d want 33", n); end
    repeat (3) @(negedge clk);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL stall_relaunch got %0b want 0", Busy); end
    n_cmp++; if (Lo !== 32'd14) begin n_bad++; $display("FAIL stall_lo got %h want 14", Lo); end
    n_cmp++; if (Hi !== 32'd2) begin n_bad++; $display("FAIL stall_hi got %h want 2", Hi); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; Op = 3'b001; RsData = 32'd5; RtData = 32'd5;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %0b want 0", Busy); end
    @(negedge clk);
    n_cmp++; if (Hi !== 32'd2) begin n_bad++; $display("FAIL flush_hi got %h want 2", Hi); end
    n_cmp++; if (Lo !== 32'd14) begin n_bad++; $display("FAIL flush_lo got %h want 14", Lo); end
  endtask

  task automatic test_back_to_back;
    int n, st;
    @(negedge clk);
    Start = 1'b1; Op = 3'b001; RsData = 32'd3; RtData = 32'd5;
    @(negedge clk);
    RsData = 32'h00010000; RtData = 32'h00010000;
    n = 0; st = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!Busy) break;
      n++;
      if (ALUStall) st++;
      @(negedge clk);
    end
    n_cmp++; if (st != 33) begin n_bad++; $display("FAIL b2b_stall got %0d want 33", st); end
    n_cmp++; if (Lo !== 32'd15) begin n_bad++; $display("FAIL b2b_first_lo got %h want 15", Lo); end
    n_cmp++; if (Hi !== 32'd0) begin n_bad++; $display("FAIL b2b_first_hi got %h want 0", Hi); end
    @(negedge clk);
    Start = 1'b0; RsData = 32'hBAD0BAD0; RtData = 32'h12345678;
    #1;
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_launch got %0b want 1", Busy); end
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!Busy) break;
      n++;
      @(negedge clk);
      #1;
    end
    n_cmp++; if (n != 33) begin n_bad++; $display("FAIL b2b_busy got %0d want 33", n); end
    n_cmp++; if (Hi !== 32'd1) begin n_bad++; $display("FAIL b2b_second_hi got %h want 1", Hi); end
    n_cmp++; if (Lo !== 32'd0) begin n_bad++; $display("FAIL b2b_second_lo got %h want 0", Lo); end
  endtask

  task automatic test_async_reset_mt;
    int n;
    @(negedge clk);
    Start = 1'b1; Op = 3'b001; RsData = 32'hFFFFFFFF; RtData = 32'hFFFFFFFF;
    @(negedge clk);
    Start = 1'b0; n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy got %0b want 0", Busy); end
    n_cmp++; if (Hi !== 32'h0) begin n_bad++; $display("FAIL areset_hi got %h want 0", Hi); end
    n_cmp++; if (Lo !== 32'h0) begin n_bad++; $display("FAIL areset_lo got %h want 0", Lo); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    Start = 1'b1; Op = 3'b100; RsData = 32'hDEADBEEF;
    @(negedge clk);
    Start = 1'b0; ReadHiLo = 1'b1; ReadHiSel = 1'b1;
    #1;
    n_cmp++; if (HiLoOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mthi_value got %h want deadbeef", HiLoOut); end
    n_cmp++; if (ALUStall !== 1'b0) begin n_bad++; $display("FAIL mthi_stall got %0b want 0", ALUStall); end
    ReadHiLo = 1'b0;
    @(negedge clk);
    Start = 1'b1; Op = 3'b101; RsData = 32'h12345678;
    @(negedge clk);
    Start = 1'b0; ReadHiLo = 1'b1; ReadHiSel = 1'b0;
    #1;
    n_cmp++; if (HiLoOut !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_value got %h want 12345678", HiLoOut); end
    n_cmp++; if (Hi !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mtlo_hi_kept got %h want deadbeef", Hi); end
    ReadHiLo = 1'b0;
    @(negedge clk);
    Start = 1'b1; Op = 3'b110; RsData = 32'h55555555;
    @(negedge clk);
    Start = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL badop_busy got %0b want 0", Busy); end
    n_cmp++; if (Hi !== 32'hDEADBEEF) begin n_bad++; $display("FAIL badop_hi got %h want deadbeef", Hi); end
    n_cmp++; if (Lo !== 32'h12345678) begin n_bad++; $display("FAIL badop_lo got %h want 12345678", Lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_corner();
    test_mfhi_stall();
    test_stall_hold();
    test_flush();
    test_back_to_back();
    test_async_reset_mt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
